// File: rtl/thermal_plant_model.sv
`default_nettype none
// ============================================================================
// Module   : thermal_plant_model
// Purpose  : Multi-channel thermal plant model. Each channel holds a
//            temperature that moves one degree per divided-clock tick toward
//            its target. The fan speed and the heating/cooling direction set
//            the divide ratio. A shared 16-bit LFSR loads every channel with a
//            bounded pseudo-random start temperature during an init window
//            that follows reset.
// Ports    : CLK          - clock, rising edge
//            nRST         - asynchronous active-low reset
//            seed[15:0]   - LFSR reset value (0 is replaced by 16'h0001)
//            enable[NCH]  - per-channel run enable
//            fan_speed    - 2 bits per channel, channel i at [2i+1:2i]
//            heating[NCH] - 1 = rise toward target, 0 = fall toward target
//            target       - TW bits per channel, channel i at [TW*i +: TW]
//            temperature  - current temperatures, same packing as target
//            step[NCH]    - one-cycle pulse when a tick changed the value
//            at_target    - temperature == target (combinational)
//            init_done    - random-load window finished
// Revision : 1.0 - initial release
// ============================================================================
module thermal_plant_model #(
    parameter int NCH         = 4,
    parameter int TW          = 7,
    parameter int DIVW        = 8,
    parameter int SLOW_DIV    = 30,
    parameter int MED_DIV     = 18,
    parameter int FAST_DIV    = 12,
    parameter int INIT_CYCLES = 10,
    parameter int T_MIN       = 30,
    parameter int T_MAX       = 90
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [15:0]         seed,
    input  logic [NCH-1:0]      enable,
    input  logic [2*NCH-1:0]    fan_speed,
    input  logic [NCH-1:0]      heating,
    input  logic [TW*NCH-1:0]   target,
    output logic [TW*NCH-1:0]   temperature,
    output logic [NCH-1:0]      step,
    output logic [NCH-1:0]      at_target,
    output logic                init_done
);

    localparam int ICW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    localparam logic [DIVW-1:0] c_slow_div = DIVW'(SLOW_DIV);
    localparam logic [DIVW-1:0] c_med_div  = DIVW'(MED_DIV);
    localparam logic [DIVW-1:0] c_fast_div = DIVW'(FAST_DIV);
    localparam logic [DIVW-1:0] c_div_one  = DIVW'(1);
    localparam logic [TW-1:0]   c_t_min    = TW'(T_MIN);
    localparam logic [TW-1:0]   c_t_max    = TW'(T_MAX);
    // Raw values above T_MAX are folded down by this amount, which maps the
    // top of the raw range exactly onto T_MAX.
    localparam logic [TW-1:0]   c_hi_off   = TW'((2 ** TW) - 1 - T_MAX);
    localparam logic [ICW-1:0]  c_init_len = ICW'(INIT_CYCLES);

    // ------------------------------------------------------------------
    // Shared LFSR and init window
    // ------------------------------------------------------------------
    logic [15:0]    lfsr_q, lfsr_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    logic           init_done_q, init_done_d;

    always_comb begin
        // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        init_cnt_d  = (init_cnt_q != '0) ? init_cnt_q - ICW'(1) : '0;
        // Set by the same edge that loads the last random start value
        init_done_d = (init_cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lfsr_q      <= (seed == 16'h0000) ? 16'h0001 : seed;
            init_cnt_q  <= c_init_len;
            init_done_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // ------------------------------------------------------------------
    // Per-channel divider and temperature integrator
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [TW-1:0]   raw, rnd, tgt;
        logic [TW-1:0]   temp_q, temp_d;
        logic [DIVW-1:0] div, cnt_q, cnt_d;
        logic            tick;
        logic            step_q, step_d;

        always_comb begin
            raw = lfsr_q[i +: TW];
            tgt = target[TW*i +: TW];

            // Fold the raw value into [T_MIN, T_MAX]
            if (raw < c_t_min) begin
                rnd = raw + c_t_min;
            end else if (raw > c_t_max) begin
                rnd = raw - c_hi_off;
            end else begin
                rnd = raw;
            end

            // Fan speeds 01 and 11 swap slow/fast between heating and cooling
            case (fan_speed[2*i +: 2])
                2'b00:   div = c_div_one;
                2'b01:   div = heating[i] ? c_fast_div : c_slow_div;
                2'b10:   div = c_med_div;
                default: div = heating[i] ? c_slow_div : c_fast_div;
            endcase

            // Compare with >= so lowering the ratio below the running count
            // produces a tick on the next edge instead of a wrap.
            tick  = 1'b0;
            cnt_d = '0;
            if (enable[i] && init_done_q) begin
                if (cnt_q >= div - c_div_one) begin
                    tick = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_div_one;
                end
            end

            temp_d = temp_q;
            step_d = 1'b0;
            if (init_cnt_q != '0) begin
                temp_d = rnd;
            end else if (tick) begin
                // Never step past the target, so no wrap is possible
                if (heating[i] && (temp_q < tgt)) begin
                    temp_d = temp_q + TW'(1);
                    step_d = 1'b1;
                end else if (!heating[i] && (temp_q > tgt)) begin
                    temp_d = temp_q - TW'(1);
                    step_d = 1'b1;
                end
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                cnt_q  <= '0;
                temp_q <= '0;
                step_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                temp_q <= temp_d;
                step_q <= step_d;
            end
        end

        assign temperature[TW*i +: TW] = temp_q;
        assign step[i]                 = step_q;
        assign at_target[i]            = (temp_q == tgt);
    end

endmodule
`default_nettype wire

// File: tb/tb_thermal_plant_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermal_plant_model
// Purpose  : Self-checking bench for thermal_plant_model. A behavioural plant
//            model tracks elapsed edges per channel and is compared against
//            every output on each falling edge; directed sequences and a
//            period table cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thermal_plant_model;

    localparam int NCH         = 4;
    localparam int TW          = 7;
    localparam int DIVW        = 8;
    localparam int SLOW_DIV    = 30;
    localparam int MED_DIV     = 18;
    localparam int FAST_DIV    = 12;
    localparam int INIT_CYCLES = 10;
    localparam int T_MIN       = 30;
    localparam int T_MAX       = 90;
    localparam int TOP         = (2 ** TW) - 1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [15:0]       seed = 16'h0000;
    logic [NCH-1:0]    enable = '0;
    logic [2*NCH-1:0]  fan_speed = '0;
    logic [NCH-1:0]    heating = '0;
    logic [TW*NCH-1:0] target = '0;
    logic [TW*NCH-1:0] temperature;
    logic [NCH-1:0]    step;
    logic [NCH-1:0]    at_target;
    logic              init_done;

    always #5 CLK = ~CLK;

    thermal_plant_model #(
        .NCH(NCH), .TW(TW), .DIVW(DIVW), .SLOW_DIV(SLOW_DIV), .MED_DIV(MED_DIV),
        .FAST_DIV(FAST_DIV), .INIT_CYCLES(INIT_CYCLES), .T_MIN(T_MIN), .T_MAX(T_MAX)
    ) dut (
        .CLK(CLK), .nRST(nRST), .seed(seed), .enable(enable), .fan_speed(fan_speed),
        .heating(heating), .target(target), .temperature(temperature), .step(step),
        .at_target(at_target), .init_done(init_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    int m_temp [NCH];
    int m_el   [NCH];   // edges elapsed in the current tick period
    bit m_step [NCH];
    int m_lfsr;
    int m_left;
    bit m_done;

    function automatic int rnd_of(input int lf, input int ch);
        int raw;
        raw = (lf >> ch) % (TOP + 1);
        if (raw < T_MIN) return raw + T_MIN;
        if (raw > T_MAX) return raw - (TOP - T_MAX);
        return raw;
    endfunction

    function automatic int period(input int fs, input bit h);
        case (fs)
            0:       return 1;
            1:       return h ? FAST_DIV : SLOW_DIV;
            2:       return MED_DIV;
            default: return h ? SLOW_DIV : FAST_DIV;
        endcase
    endfunction

    function automatic int tgt_of(input int ch);
        return int'(target[TW*ch +: TW]);
    endfunction

    function automatic int temp_of(input int ch);
        return int'(temperature[TW*ch +: TW]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        int d, t;
        if (!nRST) begin
            for (int c = 0; c < NCH; c++) begin
                m_temp[c] = 0; m_el[c] = 0; m_step[c] = 0;
            end
            m_lfsr = (seed == 16'h0000) ? 1 : int'(seed);
            m_left = INIT_CYCLES;
            m_done = 0;
        end else begin
            if (m_left > 0) begin
                for (int c = 0; c < NCH; c++) begin
                    m_temp[c] = rnd_of(m_lfsr, c);
                    m_step[c] = 0;
                end
                m_left--;
                if (m_left == 0) m_done = 1;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    m_step[c] = 0;
                    if (enable[c] && m_done) begin
                        d = period(int'(fan_speed[2*c +: 2]), heating[c]);
                        m_el[c]++;
                        if (m_el[c] >= d) begin
                            m_el[c] = 0;
                            t = tgt_of(c);
                            if (heating[c] && m_temp[c] < t) begin
                                m_temp[c]++; m_step[c] = 1;
                            end else if (!heating[c] && m_temp[c] > t) begin
                                m_temp[c]--; m_step[c] = 1;
                            end
                        end
                    end else begin
                        m_el[c] = 0;
                    end
                end
            end
            m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | ($countones(m_lfsr & 16'hB400) & 1);
        end
    end

    // Continuous comparison on the falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("temp%0d", c), temperature[TW*c +: TW], m_temp[c]);
                check($sformatf("step%0d", c), step[c], m_step[c]);
                check($sformatf("at_target%0d", c), at_target[c], (m_temp[c] == tgt_of(c)));
            end
            check("init_done", init_done, m_done);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drv_wait();
        @(negedge CLK); #1;
    endtask

    task automatic edge1();
        @(posedge CLK); #1;
    endtask

    task automatic set_ch(input int ch, input int fs, input bit h, input int t, input bit en);
        fan_speed[2*ch +: 2] = 2'(fs);
        heating[ch]          = h;
        target[TW*ch +: TW]  = TW'(t);
        enable[ch]           = en;
    endtask

    typedef struct {
        int fs;
        bit heat;
        int per;
    } vec_t;

    vec_t vt [7];
    int   st [NCH];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, n, ns [NCH];

        vt[0] = '{0, 1'b1, 1};
        vt[1] = '{1, 1'b1, FAST_DIV};
        vt[2] = '{1, 1'b0, SLOW_DIV};
        vt[3] = '{2, 1'b1, MED_DIV};
        vt[4] = '{2, 1'b0, MED_DIV};
        vt[5] = '{3, 1'b1, SLOW_DIV};
        vt[6] = '{3, 1'b0, FAST_DIV};

        // Reset with seed 0, then release
        repeat (3) drv_wait();
        chk_en = 1'b1;
        check("rst_init_done", init_done, 0);
        check("rst_temp_all", temperature, 0);
        nRST = 1'b1;

        // Init window: bounded random starts, no steps, init_done on edge 10
        for (int e = 1; e <= INIT_CYCLES; e++) begin
            edge1();
            for (int c = 0; c < NCH; c++)
                check("init_range", (temp_of(c) >= T_MIN) && (temp_of(c) <= T_MAX), 1);
            check("init_step", step, 0);
            check("init_done_edge", init_done, (e == INIT_CYCLES));
        end
        for (int c = 0; c < NCH; c++) st[c] = m_temp[c];

        // Channel 0: heating at FAST_DIV to start+3
        drv_wait();
        set_ch(0, 1, 1'b1, st[0] + 3, 1'b1);
        n = 0;
        for (int e = 1; e <= 3 * FAST_DIV + 9; e++) begin
            edge1();
            if (step[0]) begin
                n++;
                if (n <= 3) check("ch0_step_edge", e, FAST_DIV * n);
            end
        end
        check("ch0_step_count", n, 3);
        check("ch0_final", temp_of(0), st[0] + 3);
        check("ch0_at_target", at_target[0], 1);

        // Channel 1: cooling at FAST_DIV, switch to D=1 with count at 7
        drv_wait();
        set_ch(1, 3, 1'b0, 0, 1'b1);
        repeat (7) edge1();
        check("ch1_no_step_yet", temp_of(1), st[1]);
        drv_wait();
        fan_speed[3:2] = 2'b00;
        edge1();
        check("ch1_fast_tick", step[1], 1);
        check("ch1_fast_val", temp_of(1), st[1] - 1);
        k = 1;
        while (temp_of(1) != 0 && k < 200) begin
            edge1();
            k++;
        end
        check("ch1_edges_to_zero", k, st[1]);
        repeat (3) edge1();
        check("ch1_hold_zero", temp_of(1), 0);
        check("ch1_hold_step", step[1], 0);

        // All channels at MED_DIV, independent directions/targets
        drv_wait();
        set_ch(0, 2, 1'b1, st[0] + 3, 1'b1);
        set_ch(1, 2, 1'b1, 20, 1'b1);
        set_ch(2, 2, 1'b0, 10, 1'b1);
        set_ch(3, 2, 1'b1, 120, 1'b1);
        for (int c = 0; c < NCH; c++) ns[c] = 0;
        for (int e = 1; e <= 4 * MED_DIV; e++) begin
            edge1();
            for (int c = 0; c < NCH; c++) if (step[c]) ns[c]++;
        end
        check("sim_ch0_steps", ns[0], 0);
        check("sim_ch1_steps", ns[1], 4);
        check("sim_ch2_steps", ns[2], 4);
        check("sim_ch3_steps", ns[3], 4);

        // Enable toggle on channel 3: freeze, then a full period
        drv_wait();
        enable[3] = 1'b0;
        n = m_temp[3];
        repeat (5) begin
            edge1();
            check("frz_temp", temp_of(3), n);
            check("frz_step", step[3], 0);
        end
        drv_wait();
        enable[3] = 1'b1;
        k = 0;
        do begin edge1(); k++; end while (!step[3] && k < 60);
        check("reen_period", k, MED_DIV);

        // Period table on channel 2
        for (int v = 0; v < 7; v++) begin
            drv_wait();
            enable[2] = 1'b0;
            edge1();
            drv_wait();
            set_ch(2, vt[v].fs, vt[v].heat, vt[v].heat ? TOP : 0, 1'b1);
            for (int p = 0; p < 2; p++) begin
                k = 0;
                do begin edge1(); k++; end while (!step[2] && k < 80);
                check($sformatf("tbl%0d_period%0d", v, p), k, vt[v].per);
            end
        end

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drv_wait();
            if ($urandom_range(0, 7) == 0) begin
                set_ch($urandom_range(0, NCH - 1), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), $urandom_range(0, TOP),
                       ($urandom_range(0, 3) != 0));
            end
        end

        // Asynchronous reset mid-ramp, then re-init with the same seed
        drv_wait();
        set_ch(0, 0, 1'b1, TOP, 1'b1);
        repeat (3) edge1();
        @(posedge CLK); #3;
        nRST = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) begin
            check("arst_temp", temp_of(c), 0);
            check("arst_at_target", at_target[c], (tgt_of(c) == 0));
        end
        check("arst_step", step, 0);
        check("arst_init_done", init_done, 0);
        drv_wait();
        drv_wait();
        nRST = 1'b1;
        for (int e = 1; e <= INIT_CYCLES; e++) edge1();
        for (int c = 0; c < NCH; c++) check("reinit_temp", temp_of(c), st[c]);
        check("reinit_done", init_done, 1);
        repeat (4) edge1();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
